// File: rtl/recon_luma16x16.sv
// Intra 16x16 luma reconstruction: adds one residual row per cycle to a
// vertical, horizontal or DC prediction with 8-bit modular wrap.
//
// state | meaning
// IDLE  | waiting for start; residual input not accepted
// RUN   | predictors latched; rows 0..15 accepted, reconstructed and handed downstream
module recon_luma16x16 #(
    parameter int BITDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [15:0][BITDEPTH-1:0] top,
    input  logic [15:0][BITDEPTH-1:0] left,
    input  logic [BITDEPTH-1:0]       dc,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [15:0][BITDEPTH-1:0] res_row,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [15:0][BITDEPTH-1:0] rec_row,
    output logic [3:0]                rec_row_idx,
    output logic                      busy,
    output logic                      mb_done
);

    generate
        if (BITDEPTH != 8) begin : g_bitdepth_check
            $error("recon_luma16x16: only BITDEPTH = 8 is supported");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                      state;
    logic [1:0]                  mode_q;
    logic [15:0][BITDEPTH-1:0]   top_q;
    logic [15:0][BITDEPTH-1:0]   left_q;
    logic [BITDEPTH-1:0]         dc_q;
    logic [4:0]                  acc_cnt;
    logic                        accept;
    logic                        consume;
    logic [15:0][BITDEPTH-1:0]   pred;
    logic [15:0][BITDEPTH-1:0]   sum;

    // acc_cnt reaching 16 stops intake so row 15 is the last one accepted
    assign res_ready = (state == RUN) && (!rec_valid || rec_ready) && !acc_cnt[4];
    assign accept    = res_valid && res_ready;
    assign consume   = rec_valid && rec_ready;

    always_comb begin
        pred = '0;
        sum  = '0;
        for (int c = 0; c < 16; c++) begin
            unique case (mode_q)
                2'd0:    pred[c] = top_q[c];
                2'd1:    pred[c] = left_q[acc_cnt[3:0]];
                default: pred[c] = dc_q;
            endcase
            sum[c] = res_row[c] + pred[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mode_q      <= '0;
            top_q       <= '0;
            left_q      <= '0;
            dc_q        <= '0;
            acc_cnt     <= '0;
            rec_valid   <= 1'b0;
            rec_row     <= '0;
            rec_row_idx <= '0;
            busy        <= 1'b0;
            mb_done     <= 1'b0;
        end else begin
            mb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        top_q   <= top;
                        left_q  <= left;
                        dc_q    <= dc;
                        acc_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        rec_row     <= sum;
                        rec_row_idx <= acc_cnt[3:0];
                        rec_valid   <= 1'b1;
                        acc_cnt     <= acc_cnt + 5'd1;
                    end else if (consume) begin
                        rec_valid <= 1'b0;
                    end
                    if (consume && rec_row_idx == 4'd15) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        mb_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recon_luma16x16.sv
// Directed bench for recon_luma16x16: prediction modes, wrap, backpressure,
// start filtering and mid-block reset.
module tb_recon_luma16x16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [1:0]            mode = '0;
    logic [15:0][7:0]      top = '0;
    logic [15:0][7:0]      left = '0;
    logic [7:0]            dc = '0;
    logic                  res_valid = 1'b0;
    logic                  res_ready;
    logic [15:0][7:0]      res_row = '0;
    logic                  rec_valid;
    logic                  rec_ready = 1'b1;
    logic [15:0][7:0]      rec_row;
    logic [3:0]            rec_row_idx;
    logic                  busy;
    logic                  mb_done;

    int checks = 0;
    int errors = 0;

    recon_luma16x16 #(.BITDEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .top        (top),
        .left       (left),
        .dc         (dc),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_row    (res_row),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_row    (rec_row),
        .rec_row_idx(rec_row_idx),
        .busy       (busy),
        .mb_done    (mb_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0][15:0][7:0] fill(input logic [7:0] v);
        logic [15:0][15:0][7:0] m;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                m[r][c] = v;
        return m;
    endfunction

    task automatic do_start(input logic [1:0] m, input logic [15:0][7:0] t,
                            input logic [15:0][7:0] l, input logic [7:0] d);
        @(negedge clk);
        mode      = m;
        top       = t;
        left      = l;
        dc        = d;
        start     = 1'b1;
        rec_ready = 1'b1;
        res_valid = 1'b0;
    endtask

    // Drives rows after a do_start; iteration n precedes the n-th edge after the start edge.
    task automatic stream(input logic [15:0][15:0][7:0] res_rows,
                          input logic [15:0][15:0][7:0] exp_rows,
                          input int stall_row, input int stall_cycles,
                          input int stop_after, input int start_iter,
                          input logic [15:0][7:0] alt_top,
                          input int exp_last_edge, input string name);
        int tx = 0;
        int rx = 0;
        int it = 0;
        int stalled = 0;
        int last_edge = -1;
        while (rx < stop_after && it < 200) begin
            @(negedge clk);
            it++;
            start = (it == start_iter);
            if (it == start_iter) top = alt_top;
            if (rec_valid && int'(rec_row_idx) == stall_row && stalled < stall_cycles) begin
                rec_ready = 1'b0;
                stalled++;
            end else begin
                rec_ready = 1'b1;
            end
            res_valid = (tx < 16);
            if (tx < 16) res_row = res_rows[tx];
            #1;
            if (it == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
                end
            end
            if (!rec_ready) begin
                checks++;
                if (res_ready !== 1'b0 || rec_row_idx !== stall_row[3:0] ||
                    rec_row !== exp_rows[stall_row]) begin
                    errors++;
                    $display("FAIL %s stall_hold: res_ready %b idx %0d row %h, expected 0 idx %0d row %h",
                             name, res_ready, rec_row_idx, rec_row, stall_row, exp_rows[stall_row]);
                end
            end
            if (res_valid && res_ready) tx++;
            if (rec_valid && rec_ready) begin
                checks++;
                if (rec_row_idx !== rx[3:0] || rec_row !== exp_rows[rx]) begin
                    errors++;
                    $display("FAIL %s row%0d: got idx %0d row %h expected idx %0d row %h",
                             name, rx, rec_row_idx, rec_row, rx, exp_rows[rx]);
                end
                rx++;
                last_edge = it;
            end
        end
        res_valid = 1'b0;
        checks++;
        if (rx < stop_after) begin
            errors++;
            $display("FAIL %s timeout: got %0d rows expected %0d", name, rx, stop_after);
        end
        if (exp_last_edge > 0) begin
            checks++;
            if (last_edge != exp_last_edge) begin
                errors++;
                $display("FAIL %s latency: last consume on edge %0d expected %0d",
                         name, last_edge, exp_last_edge);
            end
        end
        if (rx == 16) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (mb_done !== 1'b1 || busy !== 1'b0 || res_ready !== 1'b0 || rec_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse: mb_done %b busy %b res_ready %b rec_valid %b expected 1 0 0 0",
                         name, mb_done, busy, res_ready, rec_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (mb_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s done_end: mb_done %b busy %b expected 0 0", name, mb_done, busy);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rec_valid !== 1'b0 || busy !== 1'b0 || mb_done !== 1'b0 || res_ready !== 1'b0 ||
            rec_row_idx !== 4'd0 || rec_row !== '0) begin
            errors++;
            $display("FAIL reset_state: valid %b busy %b done %b ready %b idx %0d row %h expected all 0",
                     rec_valid, busy, mb_done, res_ready, rec_row_idx, rec_row);
        end
        @(negedge clk);
        reset     = 1'b0;
        res_valid = 1'b1;
        res_row   = fill(8'h33)[0];
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (res_ready !== 1'b0 || rec_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: ready %b valid %b busy %b expected 0 0 0",
                     res_ready, rec_valid, busy);
        end
        res_valid = 1'b0;
    endtask

    task automatic test_vertical;
        logic [15:0][7:0]       t;
        logic [15:0][15:0][7:0] e;
        for (int c = 0; c < 16; c++) t[c] = 8'(c);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) e[r][c] = 8'(c + 10);
        do_start(2'd0, t, '0, 8'd0);
        // start raised on the final consume edge must be ignored
        stream(fill(8'd10), e, -1, 0, 16, 17, t, 17, "vertical");
    endtask

    task automatic test_horizontal;
        logic [15:0][7:0]       l;
        logic [15:0][15:0][7:0] e;
        do_start(2'd1, '0, fill(8'd250)[0], 8'd0);
        stream(fill(8'd10), fill(8'd4), -1, 0, 16, 0, '0, 17, "horiz_wrap");
        do_start(2'd1, '0, fill(8'd5)[0], 8'd0);
        stream(fill(8'hF6), fill(8'hFB), -1, 0, 16, 0, '0, 17, "horiz_neg");
        for (int r = 0; r < 16; r++) begin
            l[r] = 8'(r * 16);
            for (int c = 0; c < 16; c++) e[r][c] = 8'(r * 16 + 1);
        end
        do_start(2'd1, '0, l, 8'd0);
        stream(fill(8'd1), e, -1, 0, 16, 0, '0, 17, "horiz_rows");
    endtask

    task automatic test_dc;
        do_start(2'd2, '0, '0, 8'd128);
        stream(fill(8'h80), fill(8'h00), -1, 0, 16, 0, '0, 17, "dc_mode2");
        do_start(2'd3, '0, '0, 8'd128);
        stream(fill(8'h80), fill(8'h00), -1, 0, 16, 0, '0, 17, "dc_mode3");
    endtask

    task automatic test_backpressure;
        logic [15:0][7:0]       t;
        logic [15:0][15:0][7:0] rs;
        logic [15:0][15:0][7:0] e;
        for (int c = 0; c < 16; c++) t[c] = 8'(c * 3);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                rs[r][c] = 8'(r);
                e[r][c]  = 8'(c * 3 + r);
            end
        do_start(2'd0, t, '0, 8'd0);
        stream(rs, e, 2, 3, 16, 0, '0, 20, "backpressure");
    endtask

    task automatic test_start_in_run;
        logic [15:0][7:0]       t;
        logic [15:0][15:0][7:0] e;
        for (int c = 0; c < 16; c++) t[c] = 8'(c + 100);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) e[r][c] = 8'(c + 100 + 7);
        do_start(2'd0, t, '0, 8'd0);
        stream(fill(8'd7), e, -1, 0, 16, 5, fill(8'hAA)[0], 17, "start_in_run");
    endtask

    task automatic test_reset_mid;
        logic [15:0][7:0]       l;
        logic [15:0][15:0][7:0] e;
        int                     seen_done = 0;
        for (int r = 0; r < 16; r++) begin
            l[r] = 8'(r);
            for (int c = 0; c < 16; c++) e[r][c] = 8'(r);
        end
        do_start(2'd1, '0, l, 8'd0);
        stream(fill(8'd0), e, -1, 0, 8, 0, '0, 0, "pre_reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (rec_valid !== 1'b0 || busy !== 1'b0 || mb_done !== 1'b0 || res_ready !== 1'b0 ||
            rec_row_idx !== 4'd0 || rec_row !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid %b busy %b done %b ready %b idx %0d row %h expected all 0",
                     rec_valid, busy, mb_done, res_ready, rec_row_idx, rec_row);
        end
        @(negedge clk);
        reset     = 1'b0;
        res_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (mb_done || busy || res_ready) seen_done++;
        end
        res_valid = 1'b0;
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_abandon: %0d cycles with done/busy/ready set, expected 0", seen_done);
        end
        do_start(2'd2, '0, '0, 8'd1);
        stream(fill(8'd0), fill(8'd1), -1, 0, 16, 0, '0, 17, "post_reset");
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_horizontal();
        test_dc();
        test_backpressure();
        test_start_in_run();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
